// File: rtl/ifetch_unit_if.sv
// Fetch unit bus: imem address/data, branch redirect and the decode-side valid/ready port.
// master = fetch unit, slave = surrounding core (imem + decode + branch logic).
interface ifetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        misalign_err;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_pc_plus4,
        output misalign_err
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_pc_plus4,
        input  misalign_err
    );
endinterface

// File: rtl/ifetch_unit.sv
// MIPS32 instruction fetch: PC register, in-order fetch queue, redirect flush.
// Optional macro IFETCH_ALIGN_CHECK_EN enables misaligned-redirect detection and HALT.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    ifetch_unit_if.master bus
);
    localparam int unsigned    PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]  PTR_ONE  = PW'(1);
    localparam logic [PW:0]    CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]    FULL_CNT = (PW + 1)'(DEPTH);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [31:0]   pc;
    logic [0:0]    state;
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          err;
    logic          full;
    logic          pop;
    logic          push;
    logic          misalign;
    logic [31:0]   target;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign misalign = (bus.redirect_pc[1:0] != 2'b00);
    assign target   = bus.redirect_pc;
`else
    assign misalign = 1'b0;
    assign target   = bus.redirect_pc & 32'hFFFF_FFFC;
`endif

    assign full = (count == FULL_CNT);
    assign pop  = bus.out_valid & bus.out_ready;
    // A push into a full queue is allowed when the head leaves in the same cycle.
    assign push = (state == ST_RUN) & ~bus.redirect_valid & (~full | pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            state  <= ST_RUN;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            err    <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc     <= target;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            state  <= misalign ? ST_HALT : ST_RUN;
            if (misalign) begin
                err <= 1'b1;
            end
        end else begin
            if (push) begin
                pc     <= pc + 32'd4;
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= pc;
            q_instr[wr_ptr] <= bus.imem_instr;
        end
    end

    assign bus.imem_addr    = pc;
    assign bus.out_valid    = (count != '0);
    assign bus.out_pc       = q_pc[rd_ptr];
    assign bus.out_instr    = q_instr[rd_ptr];
    assign bus.out_pc_plus4 = q_pc[rd_ptr] + 32'd4;
    assign bus.misalign_err = err;
endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: expected fetches queued per scenario, checked on each pop.
module tb_ifetch_unit;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic clk;
    logic rst_n;
    int unsigned n_checks;
    int unsigned n_fail;
    entry_t sb[$];

    ifetch_unit_if bus ();

    ifetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: imem_word = 32'h2001_000A;
            32'h0000_0004: imem_word = 32'h2002_0014;
            32'h0000_0008: imem_word = 32'h0022_1820;
            32'h0000_001C: imem_word = 32'h1022_FFFF;
            32'hFFFF_FFFC: imem_word = 32'h0800_0000;
            default:       imem_word = ~addr;
        endcase
    endfunction

    always_comb bus.imem_instr = imem_word(bus.imem_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        entry_t e;
        e.pc    = pc;
        e.instr = imem_word(pc);
        sb.push_back(e);
    endtask

    // One clock: score any pop taking place this cycle, then advance to the next negedge.
    task automatic cycle();
        entry_t e;
        if (rst_n && !bus.redirect_valid && bus.out_valid && bus.out_ready) begin
            check_eq("sb_expected_pop", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_eq("out_pc", bus.out_pc, e.pc);
                check_eq("out_instr", bus.out_instr, e.instr);
                check_eq("out_pc_plus4", bus.out_pc_plus4, e.pc + 32'd4);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string tag, input int unsigned max_cycles, input int unsigned exp_cycles);
        int unsigned n;
        n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            cycle();
            n++;
        end
        check_eq({tag, "_drained"}, sb.size(), 32'd0);
        check_eq({tag, "_cycles"}, n, exp_cycles);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b1;
        @(negedge clk);

        // Reset and free-running stream
        cycle();
        cycle();
        check_eq("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check_eq("rst_imem_addr", bus.imem_addr, 32'h0);
        check_eq("rst_misalign_err", {31'b0, bus.misalign_err}, 32'd0);
        rst_n = 1'b1;
        expect_fetch(32'h0);
        expect_fetch(32'h4);
        expect_fetch(32'h8);
        cycle();
        check_eq("first_valid", {31'b0, bus.out_valid}, 32'd1);
        drain("stream", 6, 3);

        // Backpressure from reset
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        cycle();
        rst_n = 1'b1;
        sb.delete();
        expect_fetch(32'h0);
        expect_fetch(32'h4);
        expect_fetch(32'h8);
        for (int i = 0; i < 3; i++) cycle();
        check_eq("bp_addr_mid", bus.imem_addr, 32'h8);
        for (int i = 0; i < 3; i++) cycle();
        check_eq("bp_addr_hold", bus.imem_addr, 32'h8);
        check_eq("bp_valid", {31'b0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1;
        drain("bp", 6, 3);

        // Redirect with a full queue and decode ready
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        cycle();
        rst_n = 1'b1;
        sb.delete();
        for (int i = 0; i < 3; i++) cycle();
        check_eq("full_head_pc", bus.out_pc, 32'h0);
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h1C;
        cycle();
        bus.redirect_valid = 1'b0;
        check_eq("redir_bubble", {31'b0, bus.out_valid}, 32'd0);
        check_eq("redir_imem_addr", bus.imem_addr, 32'h1C);
        expect_fetch(32'h1C);
        cycle();
        check_eq("redir_valid", {31'b0, bus.out_valid}, 32'd1);
        check_eq("redir_pc", bus.out_pc, 32'h1C);
        check_eq("redir_instr", bus.out_instr, 32'h1022_FFFF);
        drain("redir", 2, 1);

        // PC wrap
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        cycle();
        bus.redirect_valid = 1'b0;
        expect_fetch(32'hFFFF_FFFC);
        expect_fetch(32'h0000_0000);
        drain("wrap", 6, 3);

        // Reset mid-stream with two entries queued
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        check_eq("mid_full_valid", {31'b0, bus.out_valid}, 32'd1);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check_eq("mid_rst_valid", {31'b0, bus.out_valid}, 32'd0);
        check_eq("mid_rst_addr", bus.imem_addr, 32'h0);
        bus.out_ready = 1'b1;
        sb.delete();
        expect_fetch(32'h0);
        expect_fetch(32'h4);
        drain("mid_rst", 6, 3);

        // Misaligned redirect
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h6;
        cycle();
        bus.redirect_valid = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
        check_eq("mis_err", {31'b0, bus.misalign_err}, 32'd1);
        check_eq("mis_addr", bus.imem_addr, 32'h6);
        for (int i = 0; i < 4; i++) begin
            check_eq("mis_halt_valid", {31'b0, bus.out_valid}, 32'd0);
            cycle();
        end
        check_eq("mis_addr_hold", bus.imem_addr, 32'h6);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h10;
        cycle();
        bus.redirect_valid = 1'b0;
        expect_fetch(32'h10);
        expect_fetch(32'h14);
        drain("mis_resume", 6, 3);
        check_eq("mis_err_sticky", {31'b0, bus.misalign_err}, 32'd1);
`else
        check_eq("mis_err", {31'b0, bus.misalign_err}, 32'd0);
        check_eq("mis_addr", bus.imem_addr, 32'h4);
        expect_fetch(32'h4);
        expect_fetch(32'h8);
        drain("mis_resume", 6, 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch unit for the MIPS32 core. It holds the program counter and drives the address port of the combinational instruction memory (`imem`). It buffers fetched words in a small in-order queue and hands `{pc, instruction}` to the decode stage over a valid/ready handshake. Branch and jump redirects flush the queue and restart fetch at the new target.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `DEPTH`, default 2: fetch queue entries; power of two, ≥2.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `imem_addr` out 32: byte address to `imem`; equals current PC.
- `imem_instr` in 32: instruction word returned combinationally by `imem` in the same cycle.
- `redirect_valid` in 1: branch/jump taken this cycle.
- `redirect_pc` in 32: target byte address, sampled when `redirect_valid`=1.
- `out_valid` out 1: queue head holds a valid instruction.
- `out_ready` in 1: decode accepts head this cycle.
- `out_instr` out 32: head instruction word.
- `out_pc` out 32: address of head instruction.
- `out_pc_plus4` out 32: `out_pc`+4, modulo 2^32.
- `misalign_err` out 1: sticky misaligned-redirect flag (see Configuration).

## Operation
- State: `pc` (32b), queue of `DEPTH` entries `{pc, instr}`, read/write pointers, count (0..DEPTH), and a 2-state FSM RUN/HALT.
- `imem_addr` = `pc` at all times (combinational from the register).
- `pop` = `out_valid & out_ready`.
- `push` = RUN & !`redirect_valid` & (count<DEPTH | `pop`). On push: enqueue `{pc, imem_instr}` and set `pc` <= `pc`+4 (32b wrap: 0xFFFF_FFFC → 0x0000_0000).
- Queue full and no pop: `pc` holds, `imem_addr` stable, no entry dropped or duplicated.
- Redirect has priority over push and pop in the same cycle. Queue is flushed (count <= 0, pointers reset), `pc` <= `redirect_pc`, and the head presented that cycle is not consumed even if `out_ready`=1.
- `out_*` are driven from the queue head and are only meaningful while `out_valid`=1.
- FSM: RUN → HALT only on a misaligned redirect with the macro defined. HALT → RUN only on a legal redirect or on reset. In HALT, no pushes occur and the queue drains normally.
- Reset (`rst_n`=0 at an edge, including mid-stream): `pc` <= `RESET_PC`, count <= 0, FSM <= RUN, `misalign_err` <= 0. Next cycle, `out_valid`=0 and `imem_addr`=`RESET_PC`.

## Timing
- Fetch-to-output latency: 1 cycle. A word pushed at edge N is visible on `out_*` during cycle N+1.
- After a redirect at edge N, the target is fetched in cycle N+1 and presented in cycle N+2. This gives a one-cycle bubble (`out_valid`=0 in cycle N+1).
- Sustained throughput is 1 instruction/cycle with `out_ready` held high.
- With the queue full, a pop and a push occur in the same cycle, so full throughput is kept.
- `out_valid` never depends combinationally on `out_ready` or on `redirect_valid`.

## Configuration
- `IFETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0 flushes the queue, sets `misalign_err`=1 (sticky until reset), and enters HALT. `pc` still loads the target so it is observable on `imem_addr`.
  - A subsequent aligned redirect returns the FSM to RUN. `misalign_err` stays 1.
- Not defined:
  - `misalign_err` is tied 0 and the FSM stays in RUN.
  - `redirect_pc[1:0]` is ignored; `pc` loads {`redirect_pc[31:2]`, 2'b00}.

## Test plan
- Reset + stream: `imem` preloaded with 0x2001000A, 0x20020014, 0x00221820 at 0x0, 0x4, 0x8; `out_ready`=1. Required: the first `out_valid` appears one cycle after reset release, and successive cycles present `out_pc` 0x0/0x4/0x8 with the matching words and `out_pc_plus4` 0x4/0x8/0xC.
- Backpressure: `out_ready`=0 for 6 cycles from reset. Required: count saturates at 2, `imem_addr` holds 0x8, and on release the outputs are 0x2001000A then 0x20020014 then 0x00221820, with no gap and no duplicate.
- Redirect: redirect to 0x1C while the queue is full and `out_ready`=1. Required: the head is not consumed, the next cycle has `out_valid`=0, and the following cycle presents `out_pc`=0x1C with `out_instr`=0x1022FFFF.
- Wrap: redirect to 0xFFFFFFFC. Required: the second fetched `out_pc` is 0x00000000.
- Reset mid-stream: assert `rst_n`=0 for 1 cycle while the queue holds 2 entries. Required: `out_valid`=0 and `imem_addr`=`RESET_PC` the next cycle, and the stream restarts at 0x0.
- Misalign (macro defined): redirect to 0x00000006. Required: `misalign_err`=1, no further valid outputs, `imem_addr`=0x6. A later redirect to 0x10 resumes fetch while `misalign_err` stays 1. With the macro undefined, the same redirect to 0x6 resumes fetch at 0x4.
